// File: rtl/core_pkg.sv
// Shared core definitions: condition-code encodings and status-register flag positions.
package core_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  localparam int unsigned N_BIT = 0;
  localparam int unsigned V_BIT = 1;
  localparam int unsigned C_BIT = 2;
  localparam int unsigned Z_BIT = 3;

endpackage

// File: rtl/cond_exec_ctrl_if.sv
// EX-stage control bundle between the pipeline and the conditional-execution controller.
interface cond_exec_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             ex_valid;
  logic             ex_stall;
  logic [3:0]       ex_cond;
  logic             ex_s;
  logic             ex_wb_en;
  logic             ex_mem_r;
  logic             ex_mem_w;
  logic             ex_branch;
  logic [3:0]       alu_flags;

  logic [3:0]       sr_q;
  logic             cc_pass;
  logic             exec;
  logic             wb_en_o;
  logic             mem_r_o;
  logic             mem_w_o;
  logic             branch_taken;
  logic             squash;
  logic [CNT_W-1:0] cnt_exec;
  logic [CNT_W-1:0] cnt_skip;

  modport master (
    output ex_valid, ex_stall, ex_cond, ex_s, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch,
           alu_flags,
    input  sr_q, cc_pass, exec, wb_en_o, mem_r_o, mem_w_o, branch_taken, squash,
           cnt_exec, cnt_skip
  );

  modport slave (
    input  ex_valid, ex_stall, ex_cond, ex_s, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch,
           alu_flags,
    output sr_q, cc_pass, exec, wb_en_o, mem_r_o, mem_w_o, branch_taken, squash,
           cnt_exec, cnt_skip
  );

endinterface

// File: rtl/cond_exec_ctrl_cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV status value.
module cond_eval
  import core_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] sr_i,
  output logic       pass_o
);

  logic n, v, c, z;

  always_comb begin
    n      = sr_i[N_BIT];
    v      = sr_i[V_BIT];
    c      = sr_i[C_BIT];
    z      = sr_i[Z_BIT];
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      CondEq:  pass_o = z;
      CondNe:  pass_o = ~z;
      CondCs:  pass_o = c;
      CondCc:  pass_o = ~c;
      CondMi:  pass_o = n;
      CondPl:  pass_o = ~n;
      CondVs:  pass_o = v;
      CondVc:  pass_o = ~v;
      CondHi:  pass_o = c & ~z;
      CondLs:  pass_o = ~c | z;
      CondGe:  pass_o = (n == v);
      CondLt:  pass_o = (n != v);
      CondGt:  pass_o = ~z & (n == v);
      CondLe:  pass_o = z | (n != v);
      CondAl:  pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// EX-stage conditional-execution controller: NZCV ownership, enable gating, branch-shadow
// squashing and executed/skipped counters.
module cond_exec_ctrl #(
  parameter int unsigned SHADOW_LEN = 2,
  parameter int unsigned CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  cond_exec_ctrl_if.slave   bus
);

  localparam logic [2:0] ShadowLoad = 3'(SHADOW_LEN);

  logic [3:0]       sr_q, sr_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_exec_q, cnt_exec_d;
  logic [CNT_W-1:0] cnt_skip_q, cnt_skip_d;

  logic cc_pass, squash, exec, advance, branch_taken;

  cond_eval u_cond_eval (
    .cond_i (bus.ex_cond),
    .sr_i   (sr_q),
    .pass_o (cc_pass)
  );

  always_comb begin
    advance      = ~bus.ex_stall;
    squash       = (shadow_q != 3'd0);
    exec         = bus.ex_valid & cc_pass & ~squash;
    branch_taken = exec & bus.ex_branch & advance;

    shadow_d = shadow_q;
    if (branch_taken) begin
      shadow_d = ShadowLoad;
    end else if (advance && squash) begin
      // Bubbles still consume shadow slots, so only stalls hold the count.
      shadow_d = shadow_q - 3'd1;
    end

    sr_d = sr_q;
    if (exec && bus.ex_s && advance) begin
      sr_d = bus.alu_flags;
    end

    cnt_exec_d = cnt_exec_q;
    cnt_skip_d = cnt_skip_q;
    if (advance && bus.ex_valid && !squash) begin
      if (cc_pass) begin
        cnt_exec_d = cnt_exec_q + CNT_W'(1);
      end else begin
        cnt_skip_d = cnt_skip_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= 4'd0;
      shadow_q   <= 3'd0;
      cnt_exec_q <= '0;
      cnt_skip_q <= '0;
    end else begin
      sr_q       <= sr_d;
      shadow_q   <= shadow_d;
      cnt_exec_q <= cnt_exec_d;
      cnt_skip_q <= cnt_skip_d;
    end
  end

  assign bus.sr_q         = sr_q;
  assign bus.cc_pass      = cc_pass;
  assign bus.exec         = exec;
  assign bus.squash       = squash;
  assign bus.branch_taken = branch_taken;
  assign bus.wb_en_o      = exec & bus.ex_wb_en & advance;
  assign bus.mem_r_o      = exec & bus.ex_mem_r & advance;
  assign bus.mem_w_o      = exec & bus.ex_mem_w & advance;
  assign bus.cnt_exec     = cnt_exec_q;
  assign bus.cnt_skip     = cnt_skip_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Scoreboard bench for cond_exec_ctrl: stimulus queues per-cycle expectations, a monitor
// on the falling edge pops and compares them.
module tb_cond_exec_ctrl;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cond_exec_ctrl_if #(.CNT_W(CW)) bus_if ();

  cond_exec_ctrl #(
    .SHADOW_LEN (2),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // -1 in any field means "not checked this cycle".
  typedef struct {
    string name;
    int    sr, cc, ex, sq, wb, mw, bt, ce, cs;
  } exp_t;

  exp_t           q[$];
  int             n_chk  = 0;
  int             n_fail = 0;
  logic [CW-1:0]  m_exec = '0;
  logic [CW-1:0]  m_skip = '0;

  task automatic exp_push(string name, int sr = -1, int cc = -1, int ex = -1, int sq = -1,
                          int wb = -1, int mw = -1, int bt = -1, int ce = -1, int cs = -1);
    exp_t e;
    e.name = name; e.sr = sr; e.cc = cc; e.ex = ex; e.sq = sq;
    e.wb = wb; e.mw = mw; e.bt = bt; e.ce = ce; e.cs = cs;
    q.push_back(e);
  endtask

  task automatic cmp(string name, string field, int act, int want);
    if (want >= 0) begin
      n_chk++;
      if (act != want) begin
        n_fail++;
        $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, want);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp(e.name, "sr_q",         int'(bus_if.sr_q),         e.sr);
      cmp(e.name, "cc_pass",      int'(bus_if.cc_pass),      e.cc);
      cmp(e.name, "exec",         int'(bus_if.exec),         e.ex);
      cmp(e.name, "squash",       int'(bus_if.squash),       e.sq);
      cmp(e.name, "wb_en_o",      int'(bus_if.wb_en_o),      e.wb);
      cmp(e.name, "mem_w_o",      int'(bus_if.mem_w_o),      e.mw);
      cmp(e.name, "branch_taken", int'(bus_if.branch_taken), e.bt);
      cmp(e.name, "cnt_exec",     int'(bus_if.cnt_exec),     e.ce);
      cmp(e.name, "cnt_skip",     int'(bus_if.cnt_skip),     e.cs);
    end
  end

  task automatic drive(bit v = 1'b0, bit st = 1'b0, logic [3:0] c = 4'hE, bit s = 1'b0,
                       logic [3:0] f = 4'h0, bit wb = 1'b0, bit mr = 1'b0, bit mw = 1'b0,
                       bit br = 1'b0);
    bus_if.ex_valid  = v;
    bus_if.ex_stall  = st;
    bus_if.ex_cond   = c;
    bus_if.ex_s      = s;
    bus_if.alu_flags = f;
    bus_if.ex_wb_en  = wb;
    bus_if.ex_mem_r  = mr;
    bus_if.ex_mem_w  = mw;
    bus_if.ex_branch = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode table: f[0]=N, f[1]=V, f[2]=C, f[3]=Z.
  function automatic int ref_cc(int c, int f);
    logic [3:0] fl;
    bit n, v, cy, z;
    fl = f[3:0];
    n = fl[0]; v = fl[1]; cy = fl[2]; z = fl[3];
    case (c)
      0:  return int'(z);
      1:  return int'(!z);
      2:  return int'(cy);
      3:  return int'(!cy);
      4:  return int'(n);
      5:  return int'(!n);
      6:  return int'(v);
      7:  return int'(!v);
      8:  return int'(cy && !z);
      9:  return int'(!cy || z);
      10: return int'(n == v);
      11: return int'(n != v);
      12: return int'(!z && (n == v));
      13: return int'(z || (n != v));
      14: return 1;
      default: return 0;
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    drive(.v(1'b0));
    repeat (2) @(posedge clk);
    #1;
    exp_push(.name("reset"), .sr(0), .cc(1), .sq(0), .ce(0), .cs(0));
    tick();
    rst = 1'b0;

    // Unconditional writes after reset
    for (int i = 0; i < 3; i++) begin
      drive(.v(1'b1), .wb(1'b1));
      exp_push(.name("al_wb"), .sr(0), .cc(1), .ex(1), .wb(1), .ce(int'(m_exec)));
      tick(); m_exec++;
    end

    // Flag set then EQ / NE consumer
    drive(.v(1'b1), .s(1'b1), .f(4'b1000));
    exp_push(.name("set_z"), .ex(1));
    tick(); m_exec++;
    drive(.v(1'b1), .c(4'h0));
    exp_push(.name("eq_after_z"), .sr(8), .cc(1), .ex(1));
    tick(); m_exec++;
    drive(.v(1'b1), .s(1'b1), .f(4'b1000));
    exp_push(.name("set_z2"), .ex(1));
    tick(); m_exec++;
    drive(.v(1'b1), .c(4'h1), .wb(1'b1));
    exp_push(.name("ne_after_z"), .sr(8), .cc(0), .ex(0), .wb(0), .cs(int'(m_skip)));
    tick(); m_skip++;
    drive(.v(1'b0));
    exp_push(.name("skip_count"), .ce(int'(m_exec)), .cs(int'(m_skip)));
    tick();

    // Full cond x flags sweep
    for (int v = 0; v < 16; v++) begin
      drive(.v(1'b1), .s(1'b1), .f(4'(v)));
      exp_push(.name("sweep_set"), .ex(1));
      tick(); m_exec++;
      for (int c = 0; c < 16; c++) begin
        drive(.v(1'b0), .c(4'(c)));
        exp_push(.name($sformatf("sweep_c%0h_sr%0h", c, v)), .sr(v), .cc(ref_cc(c, v)),
                 .ex(0));
        tick();
      end
    end

    // Taken branch, shadow of two stores, branch inside shadow ignored
    drive(.v(1'b1), .br(1'b1));
    exp_push(.name("br_take"), .bt(1), .sq(0), .ex(1));
    tick(); m_exec++;
    drive(.v(1'b1), .mw(1'b1), .br(1'b1));
    exp_push(.name("shadow1"), .sq(1), .ex(0), .mw(0), .bt(0), .ce(int'(m_exec)));
    tick();
    drive(.v(1'b1), .mw(1'b1));
    exp_push(.name("shadow2"), .sq(1), .mw(0), .ce(int'(m_exec)));
    tick();
    drive(.v(1'b1), .mw(1'b1));
    exp_push(.name("post_shadow"), .sq(0), .ex(1), .mw(1), .ce(int'(m_exec)));
    tick(); m_exec++;

    // Stalls freeze the shadow
    drive(.v(1'b1), .br(1'b1));
    exp_push(.name("br_take2"), .bt(1));
    tick(); m_exec++;
    for (int i = 0; i < 3; i++) begin
      drive(.v(1'b1), .st(1'b1), .mw(1'b1), .br(1'b1));
      exp_push(.name("stall_in_shadow"), .sq(1), .mw(0), .bt(0), .ce(int'(m_exec)));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(.v(1'b1), .mw(1'b1));
      exp_push(.name("shadow_after_stall"), .sq(1), .mw(0), .ce(int'(m_exec)));
      tick();
    end
    drive(.v(1'b1), .mw(1'b1));
    exp_push(.name("shadow_done"), .sq(0), .mw(1));
    tick(); m_exec++;

    // Stall outside shadow: enables gated, flags held
    drive(.v(1'b1), .st(1'b1), .s(1'b1), .f(4'b0101), .wb(1'b1));
    exp_push(.name("stall_gates"), .ex(1), .wb(0), .bt(0), .ce(int'(m_exec)));
    tick();
    drive(.v(1'b0));
    exp_push(.name("stall_sr_hold"), .sr(15), .ce(int'(m_exec)));
    tick();

    // Counter wrap
    while (m_exec != '1) begin
      drive(.v(1'b1));
      tick(); m_exec++;
    end
    drive(.v(1'b1));
    exp_push(.name("pre_wrap"), .ce(255));
    tick(); m_exec++;
    drive(.v(1'b0));
    exp_push(.name("wrap"), .ce(0));
    tick();

    // Reset in the middle of a shadow
    drive(.v(1'b1), .br(1'b1));
    exp_push(.name("br_take3"), .bt(1));
    tick();
    drive(.v(1'b1), .mw(1'b1));
    rst = 1'b1;
    exp_push(.name("rst_mid_shadow"), .sq(1), .mw(0));
    tick();
    rst = 1'b0;
    drive(.v(1'b1), .mw(1'b1));
    exp_push(.name("after_rst"), .sq(0), .sr(0), .mw(1), .ce(0), .cs(0));
    tick();

    drive(.v(1'b0));
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
# cond_exec_ctrl

Execute-stage conditional-execution controller for the pipelined ARM-subset core. Owns the architectural status register (NZCV), evaluates each EX-stage instruction's condition field against it, gates the writeback/memory enables, and on a taken branch squashes the fixed-length shadow of wrong-path instructions still in flight. It also keeps executed/skipped instruction counters for debug.

## Interface
- SHADOW_LEN, 2, number of EX-stage slots squashed after a taken branch (1..7)
- CNT_W, 32, width of the performance counters

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_stall  in  1  EX instruction held this cycle; no state update
- ex_cond  in  4  instruction condition field
- ex_s  in  1  instruction requests a flag update
- ex_wb_en, ex_mem_r, ex_mem_w, ex_branch  in  1 each  decoded control bits
- alu_flags  in  4  ALU flags; bit 0 N, bit 1 V, bit 2 C, bit 3 Z
- sr_q  out  4  status register, same bit order as alu_flags
- cc_pass  out  1  condition true for the current instruction
- exec  out  1  instruction commits (valid, not squashed, condition true)
- wb_en_o, mem_r_o, mem_w_o  out  1 each  ex_* gated by exec and ~ex_stall
- branch_taken  out  1  exec & ex_branch & ~ex_stall; drives PC-select
- squash  out  1  EX slot is inside a branch shadow
- cnt_exec, cnt_skip  out  CNT_W each  committed / condition-failed instruction counts

## Operation
- Condition decode against sr_q (not alu_flags):
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F reserved, never passes
- squash = (shadow counter != 0).
- exec = ex_valid & cc_pass & ~squash.
- SR update: on a cycle with exec & ex_s & ~ex_stall, sr_q <= alu_flags; otherwise sr_q holds.
- Shadow counter (3 bits; idle when 0):
  - On branch_taken, load SHADOW_LEN.
  - Otherwise, on any cycle with ~ex_stall and counter != 0, decrement.
  - Bubbles consume shadow slots.
  - A branch inside the shadow is squashed and has no effect.
- Counters update only on ~ex_stall & ex_valid & ~squash:
  - cnt_exec++ if cc_pass.
  - cnt_skip++ if not cc_pass.
  - Squashed instructions count in neither.
  - Both counters wrap modulo 2^CNT_W without saturating.

## Timing
- Reset values: sr_q 0, counter 0, cnt_exec 0, cnt_skip 0.
- Therefore after reset: squash 0, and cc_pass depends only on ex_cond with all flags clear.
- cc_pass, exec, wb_en_o, mem_r_o, mem_w_o, branch_taken and squash are combinational in the same cycle.
- sr_q has a 1-cycle latency: an instruction sees flags written by the instruction immediately before it on the following cycle; there is no same-cycle bypass.
- Shadow: with a branch taken in cycle t (no stalls), the EX slots at t+1 … t+SHADOW_LEN are squashed, and t+SHADOW_LEN+1 executes normally.
- ex_stall cycles freeze the counter, sr_q and perf counters, and force all gated enables and branch_taken to 0.
- Reset asserted mid-shadow clears the counter in the next cycle; reset takes priority over all updates.

## Structure
- Shared package (core_pkg): condition-code constants EQ..AL and NV, and flag bit indices N_BIT=0, V_BIT=1, C_BIT=2, Z_BIT=3.
- Sub-module cond_eval: purely combinational, (cond[3:0], sr[3:0]) -> pass. Instantiated once.
- Top level holds sr_q, the shadow counter and the perf counters.

## Test plan
- Reset, then ex_cond=E, ex_valid=1, ex_wb_en=1 -> wb_en_o=1, cc_pass=1, sr_q=0, cnt_exec increments by 1 per cycle.
- Instruction with ex_s=1, alu_flags=4'b1000 (Z), then next instruction ex_cond=0 (EQ) -> sr_q=4'b1000 and that instruction has exec=1. The same sequence with ex_cond=1 (NE) gives exec=0 and cnt_skip+1.
- Sweep all 16 ex_cond × 16 sr_q combinations against the decode table -> cc_pass matches in every case, including LS with C=1, Z=1 giving 1, and cond F giving 0.
- Taken branch at cycle t, then valid AL stores at t+1..t+3 -> squash=1 and mem_w_o=0 at t+1 and t+2, mem_w_o=1 at t+3, cnt_exec unchanged at t+1 and t+2.
- Taken branch followed by ex_stall=1 for 3 cycles -> squash stays 1, and the shadow still spans 2 non-stalled slots after the stall ends.
- Preload cnt_exec to all-ones via a long run (or force), then one more exec -> cnt_exec wraps to 0. Assert rst mid-shadow -> squash=0 the next cycle.
